// File: rtl/aes_pkg.sv
// AES shared constants and types.
// Used by the inverse-cipher round sequencer.
package aes_pkg;

  localparam int NR_AES128 = 10;
  localparam int NR_AES192 = 12;
  localparam int NR_AES256 = 14;

  localparam int NK_AES128 = 4;
  localparam int NK_AES192 = 6;
  localparam int NK_AES256 = 8;

  typedef logic [127:0] aes_block_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } aes_seq_state_e;

  function automatic bit aes_nr_legal(
    input int nr
  );
    return (nr == NR_AES128) ||
           (nr == NR_AES192) ||
           (nr == NR_AES256);
  endfunction

endpackage

// File: rtl/aes_dec_round_sequencer.sv
// Iterative controller for the AES inverse-cipher round datapath.
// Owns the state register; round logic and key store are external.
module aes_dec_round_sequencer
  import aes_pkg::*;
#(
  parameter int NR = NR_AES128,
  parameter int RW = $clog2(NR + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  in_block,
  output logic [RW-1:0] key_idx,
  input  logic [127:0]  round_key,
  output logic [127:0]  rnd_state,
  input  logic [127:0]  rnd_result,
  input  logic [127:0]  last_result,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  out_block,
  output logic          busy
);

  if (!aes_nr_legal(NR)) begin : g_bad_nr
    $error("NR must be 10, 12 or 14");
  end

  if (RW < $clog2(NR + 1)) begin : g_bad_rw
    $error("RW too narrow for NR");
  end

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_RUN   = RUN;
  localparam logic [1:0] S_FINAL = FINAL;
  localparam logic [1:0] S_DONE  = DONE;

  localparam logic [RW-1:0] R_LAST  = RW'(NR);
  localparam logic [RW-1:0] R_FIRST = RW'(NR - 1);
  localparam logic [RW-1:0] R_ONE   = RW'(1);

  logic [1:0]    fsm;
  logic [1:0]    fsm_d;
  logic [RW-1:0] r;
  logic [RW-1:0] r_d;
  aes_block_t    state;
  aes_block_t    state_d;

  logic st_idle;
  logic st_run;
  logic st_final;
  logic st_done;
  logic accept;

  assign st_idle  = (fsm == S_IDLE);
  assign st_run   = (fsm == S_RUN);
  assign st_final = (fsm == S_FINAL);
  assign st_done  = (fsm == S_DONE);

  // DONE can hand off and take the next block on the same edge
  assign in_ready = st_idle |
                    (st_done & out_ready);

  assign accept = in_valid & in_ready & ~flush;

  always_comb begin
    key_idx = R_LAST;
    unique case (1'b1)
      st_run:   key_idx = r;
      st_final: key_idx = '0;
      default:  key_idx = R_LAST;
    endcase
  end

  always_comb begin
    fsm_d   = fsm;
    r_d     = r;
    state_d = state;
    if (flush) begin
      fsm_d   = S_IDLE;
      r_d     = '0;
      state_d = '0;
    end else if (accept) begin
      fsm_d   = S_RUN;
      r_d     = R_FIRST;
      state_d = in_block ^ round_key;
    end else begin
      unique case (1'b1)
        st_run: begin
          state_d = rnd_result;
          if (r == R_ONE) begin
            fsm_d = S_FINAL;
            r_d   = '0;
          end else begin
            r_d = r - R_ONE;
          end
        end
        st_final: begin
          state_d = last_result;
          fsm_d   = S_DONE;
        end
        st_done: begin
          if (out_ready) begin
            fsm_d = S_IDLE;
          end
        end
        default: begin
          fsm_d = fsm;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm   <= S_IDLE;
      r     <= '0;
      state <= '0;
    end else begin
      fsm   <= fsm_d;
      r     <= r_d;
      state <= state_d;
    end
  end

  assign rnd_state = state;
  assign out_block = state;
  assign out_valid = st_done;
  assign busy      = st_run | st_final;

endmodule

// File: doc/aes_dec_round_sequencer.md
Name: aes_dec_round_sequencer

Overview:
Iterative controller for the AES inverse-cipher round datapath.
- Accepts one 128-bit ciphertext block over a valid/ready handshake.
- Performs the initial AddRoundKey itself.
- Drives the external inverse-round logic (InvShiftRows/InvSubBytes/AddRoundKey/InvMixColumns) and the final-round logic once per cycle, and indexes the expanded-key store.
- Returns the plaintext over a second valid/ready handshake.
- Sits between the block-input buffer and KeyExpansion/DecyrptRound, replacing free-running integer round counting.

Parameters:
NR, 10, number of rounds; legal values 10/12/14 (AES-128/192/256); elaboration error otherwise.
RW, $clog2(NR+1), round-counter and key-index width.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset, asynchronous and active-high; one clock; the polarity and synchronicity are fixed.
flush  input  1  synchronous abort; discards any block in flight.
in_valid  input  1  ciphertext block offered.
in_ready  output  1  sequencer can accept a block this cycle.
in_block  input  128  ciphertext, byte 0 in bits [127:120].
key_idx  output  RW  round-key index requested from the key store (0..NR).
round_key  input  128  combinational key store response for key_idx, same cycle.
rnd_state  output  128  current state register, fed to both round datapaths.
rnd_result  input  128  middle inverse-round result of rnd_state with round_key.
last_result  input  128  final inverse-round result (no InvMixColumns) with round_key.
out_valid  output  1  plaintext available.
out_ready  input  1  consumer accepts plaintext.
out_block  output  128  plaintext, equal to the state register.
busy  output  1  high in RUN or FINAL.

Behaviour:
- States: IDLE, RUN, FINAL, DONE. Registers: fsm, round counter r (RW bits), state (128).
- Reset (async, rst=1):
  - fsm=IDLE, r=0, state=0.
  - in_ready=1, out_valid=0, busy=0, key_idx=NR, out_block=0.
- key_idx:
  - IDLE and DONE: NR.
  - RUN: r.
  - FINAL: 0.
- in_ready = (fsm==IDLE) | (fsm==DONE & out_ready); combinational.
- Accept (in_valid & in_ready):
  - state <= in_block ^ round_key, using key NR.
  - r <= NR-1.
  - fsm <= RUN.
- RUN, each cycle:
  - state <= rnd_result.
  - if r==1: fsm <= FINAL, r <= 0.
  - else: r <= r-1.
- FINAL: state <= last_result; fsm <= DONE.
- DONE:
  - out_valid=1; state held while out_ready=0.
  - out_ready=1 without accept: fsm <= IDLE.
  - out_ready=1 with simultaneous accept: back-to-back, direct to RUN with the new block. No bubble.
- Latency: out_valid rises exactly NR clock edges after the accepting edge. Throughput is one block per NR+1 cycles while streaming.
- in_valid while busy: ignored, since in_ready=0. in_block is not sampled.
- flush:
  - Highest priority below rst: fsm <= IDLE, r <= 0, state <= 0.
  - An accept in the same cycle is dropped.
  - A pending out_valid is withdrawn.
- Reset mid-round: abandons the block immediately; no partial output is ever presented.
- r never underflows: RUN is entered only with r=NR-1≥9, and FINAL always uses key 0.
- No combinational path from in_valid to out_valid; only out_ready→in_ready is combinational.

Decomposition:
- Shared package aes_pkg:
  - NR_AES128/192/256 = 10/12/14 and NK_* = 4/6/8.
  - Typedef aes_block_t (logic[127:0]).
  - Enum aes_seq_state_e {IDLE, RUN, FINAL, DONE}.
- Single module, no sub-module; round datapaths and key store stay external so the sequencer is reusable with a registered key memory.

Test Plan:
- Single block, NR=10:
  - Stimulus: in_block=69c4e0d86a7b0430d8cdb78070b4c55a, key 000102030405060708090a0b0c0d0e0f, bench-connected KeyExpansion/DecyrptRound models.
  - Required: out_block=00112233445566778899aabbccddeeff, with out_valid exactly 10 edges after accept.
  - Required key_idx sequence: 10,9,…,1,0.
- Back-to-back:
  - Stimulus: two blocks streamed, with out_ready and in_valid both high in DONE.
  - Required: second accept in the same cycle, second out_valid 11 edges after the first, both plaintexts correct.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles in DONE.
  - Required: out_block stable, in_ready=0, in_valid ignored; release gives one handshake then IDLE.
- Flush in RUN:
  - Stimulus: flush at r=5.
  - Required: next cycle fsm=IDLE, state=0, no out_valid; the following block decrypts correctly.
- Async reset:
  - Stimulus: rst pulse between clock edges during FINAL.
  - Required: outputs reach reset values immediately without a clock edge, and out_valid never rises for that block.
- NR=14:
  - Stimulus: AES-256 FIPS-197 vector, ciphertext 8ea2b7ca516745bfeafc49904b496089.
  - Required: plaintext 00112233445566778899aabbccddeeff after 14 edges.
